// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the bit-serial subtractor: operands and START in,
// BUSY/DONE handshake and registered result flags out.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BI;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             BO;
  logic             OV;
  logic             Z;

  modport master (
    output START, A, B, BI,
    input  BUSY, DONE, D, BO, OV, Z
  );

  modport slave (
    input  START, A, B, BI,
    output BUSY, DONE, D, BO, OV, Z
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - BI, one bit per clock LSB first, through a single
// full-subtract cell with a registered borrow. Result registers only update on completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               CLK,
  input logic               RST_N,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;

  // Full-subtract cell on the current LSBs.
  logic             bit_a, bit_b, diff_bit, br_nxt;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    bit_a    = sa_q[0];
    bit_b    = sb_q[0];
    diff_bit = bit_a ^ bit_b ^ br_q;
    br_nxt   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    acc_nxt  = {diff_bit, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    d_d     = d_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    z_d     = z_q;

    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StShift;
          sa_d    = bus.A;
          sb_d    = bus.B;
          br_d    = bus.BI;
          cnt_d   = '0;
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
          busy_d  = 1'b1;
        end
      end
      StShift: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_nxt;
        acc_d = acc_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          d_d     = acc_nxt;
          bo_d    = br_nxt;
          z_d     = (acc_nxt == '0);
          ov_d    = (a_msb_q != b_msb_q) && (acc_nxt[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.D    = d_q;
  assign bus.BO   = bo_q;
  assign bus.OV   = ov_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor: directed corner cases, then random traffic
// checked against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    int   diff;
    diff = int'(a) - int'(b) - int'(bi);
    e.d  = W'(diff);
    e.bo = (diff < 0);
    e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    e.z  = (e.d == '0);
    return e;
  endfunction

  // Waits for idle, presents one request for one cycle, then scrambles the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input bit track, input bit in_done);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.BUSY !== 1'b0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    if (bus.BUSY !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: BUSY still 0x%0h after %0d cycles", bus.BUSY, n);
    end
    if (in_done) check("accept_in_done_cycle", 32'(bus.DONE), 32'd1);
    bus.A     = a;
    bus.B     = b;
    bus.BI    = bi;
    bus.START = 1'b1;
    if (track) sb_q.push_back(model(a, b, bi));
    @(negedge clk);
    bus.START = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.BI    = 1'($urandom);
  endtask

  // Monitor: pops on DONE, checks BUSY length, exclusivity and output hold.
  initial begin
    int   busy_run;
    exp_t last;
    exp_t got;
    exp_t e;
    busy_run = 0;
    last     = '0;
    forever begin
      @(negedge clk);
      got = {bus.D, bus.BO, bus.OV, bus.Z};
      if (rst_n !== 1'b1) begin
        busy_run = 0;
        last     = '0;
        check("in_reset_outputs", 32'({bus.BUSY, bus.DONE, got}), 32'd0);
        continue;
      end
      check("busy_done_exclusive", 32'(bus.BUSY & bus.DONE), 32'd0);
      if (bus.BUSY === 1'b1) busy_run++;
      if (bus.DONE === 1'b1) begin
        check("busy_len", 32'(busy_run), 32'(W));
        busy_run = 0;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: DONE=1 with result 0x%0h, none pending", got);
        end else begin
          e = sb_q.pop_front();
          check("result_d",  32'(got.d),  32'(e.d));
          check("result_bo", 32'(got.bo), 32'(e.bo));
          check("result_ov", 32'(got.ov), 32'(e.ov));
          check("result_z",  32'(got.z),  32'(e.z));
        end
        last = got;
      end else begin
        check("outputs_held", 32'(got), 32'(last));
      end
    end
  end

  initial begin
    int n;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.BI    = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_done", 32'(bus.DONE), 32'd0);
    check("reset_result", 32'({bus.D, bus.BO, bus.OV, bus.Z}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, back-to-back where possible.
    issue(8'h05, 8'h03, 1'b0, 1'b1, 1'b0);
    issue(8'h03, 8'h05, 1'b0, 1'b1, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    issue(8'h7F, 8'hFF, 1'b0, 1'b1, 1'b1);
    issue(8'h07, 8'h07, 1'b0, 1'b1, 1'b1);
    issue(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);

    // START while busy must be ignored.
    issue(8'h09, 8'h04, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    bus.BI    = 1'b0;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    issue(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);

    // Leave a nonzero result behind, then abort an operation with reset.
    issue(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.BUSY !== 1'b0 && n < 4 * W);
    @(negedge clk);
    issue(8'h55, 8'h11, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    check("abort_result", 32'({bus.D, bus.BO, bus.OV, bus.Z}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    issue(8'h0A, 8'h02, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((sb_q.size() != 0 || bus.BUSY !== 1'b0) && n < 8 * W) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
